// File: rtl/region_access_arb.sv
// Region access arbiter: two requesters (LSU, IFU) share one memory port.
// A round-robin grant registers the winner's request, the region decoder
// result picks a one-hot slave select, and the access completes on slave
// ready, slave error, decode fault or timeout with a one-cycle Done pulse.
module region_access_arb #(
   parameter int PA_BITS = 32,
   parameter int NREG    = 13,
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         Req,
   input  logic [PA_BITS-1:0] Adr0,
   input  logic [PA_BITS-1:0] Adr1,
   input  logic [1:0]         Size0,
   input  logic [1:0]         Size1,
   input  logic               Write0,
   input  logic [NREG-1:0]    SelRegions,
   input  logic               SlvReady,
   input  logic               SlvErr,
   output logic [PA_BITS-1:0] MemAdr,
   output logic [1:0]         MemSize,
   output logic               MemWrite,
   output logic [NREG-2:0]    HSel,
   output logic [1:0]         Gnt,
   output logic [1:0]         Done,
   output logic [1:0]         Fault,
   output logic               Busy
);

   typedef enum logic [1:0] {IDLE, DECODE, ACCESS, RESP} state_t;

   localparam logic [7:0] TO_LOAD = 8'(TIMEOUT - 1);

   state_t     state, state_nxt;
   logic       last_gnt;
   logic       win;
   logic       fault_flag;
   logic [7:0] cnt;
   logic       sel_ok;

   // True when exactly one bit of the region vector is set.
   function automatic logic is_onehot(input logic [NREG-2:0] v);
      int n;
      n = 0;
      for (int i = 0; i < NREG - 1; i++) begin
         n += int'(v[i]);
      end
      return (n == 1);
   endfunction

   // A decode is usable only if it hits a real region, and exactly one.
   assign sel_ok = ~SelRegions[0] && is_onehot(SelRegions[NREG-1:1]);

   // Round-robin winner: on contention the requester not granted last time.
   always_comb begin
      win = Req[1];
      if (Req == 2'b11) begin
         win = ~last_gnt;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|Req) state_nxt = DECODE;
         DECODE:  state_nxt = sel_ok ? ACCESS : RESP;
         ACCESS:  if (SlvReady || (cnt == 8'd0)) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Transaction registers: grant capture, slave select, timeout and fault.
   always_ff @(posedge clk) begin
      if (reset) begin
         Gnt        <= 2'b00;
         last_gnt   <= 1'b1;
         MemAdr     <= '0;
         MemSize    <= 2'b00;
         MemWrite   <= 1'b0;
         HSel       <= '0;
         cnt        <= 8'd0;
         fault_flag <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|Req) begin
                  Gnt        <= win ? 2'b10 : 2'b01;
                  last_gnt   <= win;
                  MemAdr     <= win ? Adr1 : Adr0;
                  MemSize    <= win ? Size1 : Size0;
                  MemWrite   <= win ? 1'b0 : Write0;
                  fault_flag <= 1'b0;
               end
            end
            DECODE: begin
               if (sel_ok) begin
                  HSel <= SelRegions[NREG-1:1];
                  cnt  <= TO_LOAD;
               end else begin
                  fault_flag <= 1'b1;
               end
            end
            ACCESS: begin
               if (SlvReady) begin
                  fault_flag <= SlvErr;
                  HSel       <= '0;
               end else if (cnt == 8'd0) begin
                  fault_flag <= 1'b1;
                  HSel       <= '0;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            RESP: begin
               Gnt <= 2'b00;
            end
            default: ;
         endcase
      end
   end

   assign Done  = (state == RESP) ? Gnt : 2'b00;
   assign Fault = ((state == RESP) && fault_flag) ? Gnt : 2'b00;
   assign Busy  = (state != IDLE);

endmodule

// File: tb/tb_region_access_arb.sv
// Bench for region_access_arb: directed vector table, reset-abort sequence
// and randomized transactions checked against a transaction-level model.
module tb_region_access_arb;

   localparam int PA_BITS = 32;
   localparam int NREG    = 13;
   localparam int TIMEOUT = 16;

   logic               clk = 1'b0;
   logic               reset;
   logic [1:0]         Req;
   logic [PA_BITS-1:0] Adr0, Adr1;
   logic [1:0]         Size0, Size1;
   logic               Write0;
   logic [NREG-1:0]    SelRegions;
   logic               SlvReady, SlvErr;
   logic [PA_BITS-1:0] MemAdr;
   logic [1:0]         MemSize;
   logic               MemWrite;
   logic [NREG-2:0]    HSel;
   logic [1:0]         Gnt, Done, Fault;
   logic               Busy;

   int pass_cnt  = 0;
   int total_cnt = 0;

   region_access_arb #(.PA_BITS(PA_BITS), .NREG(NREG), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .Req(Req), .Adr0(Adr0), .Adr1(Adr1),
      .Size0(Size0), .Size1(Size1), .Write0(Write0), .SelRegions(SelRegions),
      .SlvReady(SlvReady), .SlvErr(SlvErr), .MemAdr(MemAdr), .MemSize(MemSize),
      .MemWrite(MemWrite), .HSel(HSel), .Gnt(Gnt), .Done(Done), .Fault(Fault),
      .Busy(Busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  req;
      logic [1:0]  req_after;
      logic [31:0] adr0;
      logic [31:0] adr1;
      logic        w0;
      logic [12:0] sel;
      int          ready_at;   // ACCESS cycle (1-based) with SlvReady; 0 = never
      logic        err;
      logic [1:0]  exp_gnt;
      logic [1:0]  exp_fault;
      logic        exp_mw;
      int          exp_lat;
      int          exp_acc;
      logic [11:0] exp_hsel;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Runs one transaction starting from an IDLE negedge and checks it.
   task automatic run_txn(input vec_t v, input string tag);
      logic [PA_BITS-1:0] exp_adr;
      logic [1:0]         exp_size;
      logic [1:0]         got_gnt, got_done, got_fault;
      logic [11:0]        hs_seen;
      int                 lat, acc;
      bit                 seen, hold_bad, hs_bad, glitch;
      @(negedge clk);
      chk({tag, "_idle"}, 64'({Busy, Gnt, Done, Fault, HSel}), 64'd0);
      Req = v.req; Adr0 = v.adr0; Adr1 = v.adr1; Size0 = 2'd2; Size1 = 2'd1;
      Write0 = v.w0; SelRegions = v.sel; SlvReady = 1'b0; SlvErr = 1'b0;
      exp_adr  = (v.exp_gnt == 2'b10) ? v.adr1 : v.adr0;
      exp_size = (v.exp_gnt == 2'b10) ? 2'd1 : 2'd2;
      seen = 0; hold_bad = 0; hs_bad = 0; glitch = 0;
      lat = 0; acc = 0; hs_seen = '0;
      got_gnt = '0; got_done = '0; got_fault = '0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(negedge clk);
         Req = v.req_after; Adr0 = $urandom; Adr1 = $urandom;
         Size0 = 2'($urandom); Size1 = 2'($urandom); Write0 = 1'($urandom);
         SlvReady = 1'b0; SlvErr = 1'b0;
         if (MemAdr !== exp_adr || MemSize !== exp_size || MemWrite !== v.exp_mw) hold_bad = 1;
         if (Busy !== 1'b1) glitch = 1;
         if (Done == 2'b00 && Fault != 2'b00) glitch = 1;
         if (HSel != '0) begin
            acc++;
            if ($countones(HSel) != 1) hs_bad = 1;
            if (hs_seen == '0) hs_seen = HSel;
            else if (HSel !== hs_seen) hs_bad = 1;
            if (acc == v.ready_at) begin
               SlvReady = 1'b1; SlvErr = v.err;
            end
         end
         if (Done != 2'b00) begin
            seen = 1; lat = k; got_done = Done; got_fault = Fault; got_gnt = Gnt;
            if (HSel != '0) hs_bad = 1;
         end
      end
      chk({tag, "_done_seen"}, 64'(seen), 64'd1);
      chk({tag, "_gnt"},   64'(got_gnt),   64'(v.exp_gnt));
      chk({tag, "_done"},  64'(got_done),  64'(v.exp_gnt));
      chk({tag, "_fault"}, 64'(got_fault), 64'(v.exp_fault));
      chk({tag, "_lat"},   64'(lat),       64'(v.exp_lat));
      chk({tag, "_acc"},   64'(acc),       64'(v.exp_acc));
      chk({tag, "_hsel"},  64'(hs_seen),   64'(v.exp_hsel));
      chk({tag, "_hold"},  64'(hold_bad),  64'd0);
      chk({tag, "_hsel_ok"}, 64'(hs_bad),  64'd0);
      chk({tag, "_busy_fault"}, 64'(glitch), 64'd0);
      Req = 2'b00; Adr0 = '0; Adr1 = '0; Write0 = 1'b0;
   endtask

   // Transaction-level reference: winner, outcome and timing from the rules.
   int model_last;

   task automatic model_txn(input logic [1:0] req, input logic [12:0] sel,
                            input int ready_at, input logic err, input logic w0,
                            output vec_t v);
      int  win;
      bit  dec_ok;
      win = (req == 2'b11) ? ((model_last == 1) ? 0 : 1) : ((req == 2'b10) ? 1 : 0);
      model_last = win;
      dec_ok = (sel[0] == 1'b0) && ($countones(sel[12:1]) == 1);
      v.req = req; v.req_after = 2'b00; v.adr0 = $urandom; v.adr1 = $urandom;
      v.w0 = w0; v.sel = sel; v.ready_at = ready_at; v.err = err;
      v.exp_gnt = (win == 1) ? 2'b10 : 2'b01;
      v.exp_mw  = (win == 1) ? 1'b0 : w0;
      if (!dec_ok) begin
         v.exp_lat = 2; v.exp_acc = 0; v.exp_fault = v.exp_gnt; v.exp_hsel = '0;
      end else begin
         v.exp_hsel = sel[12:1];
         if (ready_at >= 1 && ready_at <= TIMEOUT) begin
            v.exp_lat = ready_at + 2; v.exp_acc = ready_at;
            v.exp_fault = err ? v.exp_gnt : 2'b00;
         end else begin
            v.exp_lat = TIMEOUT + 2; v.exp_acc = TIMEOUT; v.exp_fault = v.exp_gnt;
         end
      end
   endtask

   initial begin
      bit          done_glitch;
      vec_t        rv;
      logic [12:0] sel;
      int          a, b;

      reset = 1'b1; Req = 2'b00; Adr0 = '0; Adr1 = '0; Size0 = '0; Size1 = '0;
      Write0 = 1'b0; SelRegions = '0; SlvReady = 1'b0; SlvErr = 1'b0;

      //          req    after  adr0          adr1          w0 sel      rdy err gnt    fault  mw lat acc hsel
      vecs[0]  = '{2'b11, 2'b10, 32'h0000_1000, 32'h0000_2000, 0, 13'h004,  1, 0, 2'b01, 2'b00, 0,  3,  1, 12'h002};
      vecs[1]  = '{2'b10, 2'b00, 32'h0000_3000, 32'h0000_4000, 0, 13'h008,  2, 0, 2'b10, 2'b00, 0,  4,  2, 12'h004};
      vecs[2]  = '{2'b11, 2'b00, 32'h0000_5000, 32'h0000_6000, 1, 13'h010,  1, 0, 2'b01, 2'b00, 1,  3,  1, 12'h008};
      vecs[3]  = '{2'b01, 2'b00, 32'h1000_0000, 32'h0000_0000, 0, 13'h100,  1, 0, 2'b01, 2'b00, 0,  3,  1, 12'h080};
      vecs[4]  = '{2'b01, 2'b00, 32'hdead_0000, 32'h0000_0000, 0, 13'h0001, 1, 0, 2'b01, 2'b01, 0,  2,  0, 12'h000};
      vecs[5]  = '{2'b01, 2'b00, 32'hdead_0004, 32'h0000_0000, 1, 13'h0006, 1, 0, 2'b01, 2'b01, 1,  2,  0, 12'h000};
      vecs[6]  = '{2'b01, 2'b00, 32'h2000_0000, 32'h0000_0000, 0, 13'h002,  0, 0, 2'b01, 2'b01, 0, 18, 16, 12'h001};
      vecs[7]  = '{2'b01, 2'b00, 32'h2000_0010, 32'h0000_0000, 0, 13'h002, 16, 0, 2'b01, 2'b00, 0, 18, 16, 12'h001};
      vecs[8]  = '{2'b10, 2'b00, 32'h0000_0000, 32'h3000_0000, 1, 13'h040,  3, 1, 2'b10, 2'b10, 0,  5,  3, 12'h020};
      vecs[9]  = '{2'b01, 2'b00, 32'h4000_0000, 32'h0000_0000, 1, 13'h1000, 1, 1, 2'b01, 2'b01, 1,  3,  1, 12'h800};
      vecs[10] = '{2'b01, 2'b00, 32'h5000_0000, 32'h0000_0000, 0, 13'h0000, 1, 0, 2'b01, 2'b01, 0,  2,  0, 12'h000};
      vecs[11] = '{2'b10, 2'b00, 32'h0000_0000, 32'h6000_0000, 0, 13'h0003, 1, 0, 2'b10, 2'b10, 0,  2,  0, 12'h000};

      // Reset values.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_state", 64'({Gnt, Done, Fault, HSel, MemSize, MemWrite, Busy}), 64'd0);
      chk("reset_memadr", 64'(MemAdr), 64'd0);
      reset = 1'b0;

      // Directed vector table.
      for (int i = 0; i < 12; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

      // Reset on the second ACCESS cycle aborts without a Done pulse.
      @(negedge clk);
      Req = 2'b01; Adr0 = 32'h1000_0000; SelRegions = 13'h100; SlvReady = 1'b0;
      @(negedge clk);
      Req = 2'b00;
      @(negedge clk);
      chk("rst_pre_hsel", 64'({Busy, HSel}), 64'({1'b1, 12'h080}));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_abort", 64'({HSel, Gnt, Busy, Done}), 64'd0);
      reset = 1'b0;
      done_glitch = 0;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         if (Done != 2'b00 || Busy) done_glitch = 1;
      end
      chk("rst_no_done", 64'(done_glitch), 64'd0);

      // After reset requester 0 wins contention again; then random traffic.
      model_last = 1;
      model_txn(2'b11, 13'h020, 1, 1'b0, 1'b0, rv);
      run_txn(rv, "post_rst");
      for (int n = 0; n < 60; n++) begin
         a = $urandom_range(1, 12);
         b = (a % 12) + 1;
         case ($urandom_range(0, 5))
            0, 1, 2: sel = 13'd1 << a;
            3:       sel = (13'd1 << a) | 13'd1;
            4:       sel = (13'd1 << a) | (13'd1 << b);
            default: sel = 13'd0;
         endcase
         model_txn(2'($urandom_range(1, 3)), sel, $urandom_range(0, TIMEOUT + 3),
                   1'($urandom), 1'($urandom), rv);
         run_txn(rv, $sformatf("rnd%0d", n));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/region_access_arb.md
REGION_ACCESS_ARB -- requirements
Module: region_access_arb

Interface
REQ-001 Parameters SHALL be:
- PA_BITS, default 32, physical address width.
- NREG, default 13, width of the region-select vector; bit 0 means "no region".
- TIMEOUT, default 16, maximum ACCESS cycles before a timeout fault; legal range 1..255.

REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- Req  in  2  request per requester; [0] = data/LSU, [1] = instruction/IFU.
- Adr0, Adr1  in  PA_BITS  request address per requester.
- Size0, Size1  in  2  access size code per requester.
- Write0  in  1  data-requester write flag; requester 1 is read-only.
- SelRegions  in  NREG  decoder result for MemAdr, combinational, valid in the same cycle.
- SlvReady  in  1  selected slave completes the access.
- SlvErr  in  1  slave error; qualified by SlvReady.
- MemAdr  out  PA_BITS  registered address sent to the decoder and slaves.
- MemSize  out  2  registered size.
- MemWrite  out  1  registered write flag.
- HSel  out  NREG-1  registered one-hot slave select for regions 1..NREG-1.
- Gnt  out  2  one-hot owner of the current transaction.
- Done  out  2  one-cycle completion pulse per requester.
- Fault  out  2  access fault, valid only together with Done.
- Busy  out  1  high whenever the state is not IDLE.

Function
REQ-003 The state machine SHALL have exactly four states: IDLE, DECODE, ACCESS, RESP.

REQ-004 Req SHALL be sampled only in IDLE.
- No request: remain in IDLE.
- Any request: pick a winner (REQ-005), then on the next edge register Gnt, MemAdr, MemSize and MemWrite from the winner and go to DECODE.

REQ-005 Arbitration SHALL be round-robin with a one-bit LastGnt register.
- Both requesting: the winner is the requester not equal to LastGnt.
- One requesting: that requester wins.
- LastGnt updates on every grant.

REQ-006 When requester 1 is granted, MemWrite SHALL be registered as 0.

REQ-007 In DECODE, SelRegions SHALL be sampled and acted on as follows:
- SelRegions[0]=1, or SelRegions[NREG-1:1] not exactly one-hot: go to RESP with the fault flag set; HSel stays 0.
- Otherwise: HSel <= SelRegions[NREG-1:1], load the timeout counter with TIMEOUT-1, go to ACCESS.

REQ-008 In ACCESS, HSel SHALL remain constant and the following rules apply:
- SlvReady=1: go to RESP, fault flag <= SlvErr, HSel <= 0.
- SlvReady=0 and counter=0: go to RESP, fault flag <= 1, HSel <= 0.
- SlvReady=0 and counter nonzero: decrement the counter and stay in ACCESS.

REQ-009 SlvReady SHALL win over timeout when both occur in the same cycle, so ACCESS lasts at most TIMEOUT cycles.

REQ-010 In RESP, for one cycle only:
- Done[g]=1, where g is the granted requester.
- Fault[g]=fault flag.
- Gnt remains asserted.
- Next state is IDLE, where Gnt <= 0.

REQ-011 Done and Fault bits of the non-granted requester SHALL be 0 at all times.

REQ-012 MemAdr, MemSize and MemWrite SHALL hold their values from grant through RESP.

REQ-013 Changes on Adr, Size or Req while the block is not in IDLE SHALL have no effect on the current transaction.

REQ-014 A requester SHALL deassert Req in the cycle after its Done. A Req still high in IDLE SHALL be treated as a new request.

REQ-015 Latency SHALL be measured from the IDLE cycle in which Req is sampled to the cycle in which Done is high:
- Uncontended, SlvReady on the first ACCESS cycle: 3 cycles.
- Decode fault: 2 cycles.
- Timeout: TIMEOUT+2 cycles.

REQ-016 The minimum spacing between consecutive grants SHALL be 4 cycles for a normal access and 3 cycles for a decode fault.

REQ-017 At most one HSel bit SHALL be high in any cycle.

REQ-018 HSel SHALL be nonzero only in ACCESS.

Reset
REQ-019 On reset the block SHALL set:
- State = IDLE.
- Gnt, Done, Fault, HSel, MemAdr, MemSize, MemWrite, Busy, fault flag, counter all = 0.
- LastGnt = 1, so requester 0 wins the first contention.

REQ-020 Reset asserted in any state SHALL abort the transaction at the next edge with no Done pulse, and HSel SHALL be 0 in the following cycle.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Single access: Req=01, Adr0=0x1000_0000, SelRegions=bit 8, SlvReady on the 1st ACCESS cycle -> HSel=bit 7 for 1 cycle; Done=01, Fault=00 3 cycles after Req.
- Contention: Req=11 right after reset -> requester 0 is granted first. Holding Req[1] high then gives Gnt=10 on the next IDLE. With both high again, requester 0 wins because LastGnt=1.
- Unmapped address: SelRegions=0x0001 -> no HSel pulse; Done=01, Fault=01 2 cycles after Req. Also SelRegions=0x0006 (not one-hot) -> same response.
- Timeout: TIMEOUT=16, SlvReady held 0 -> ACCESS lasts exactly 16 cycles; Done/Fault at cycle 18. SlvReady=1 on the 16th ACCESS cycle with SlvErr=0 -> Fault=0.
- Slave error: SlvReady=1, SlvErr=1 on the 3rd ACCESS cycle with Gnt=10 -> Done=10, Fault=10; MemWrite=0 throughout, even with Write0=1.
- Reset in ACCESS: assert reset on the 2nd ACCESS cycle -> next cycle HSel=0, Gnt=0, Busy=0; no Done pulse ever appears for the aborted transaction.
